// File: rtl/opb_master_arbiter.sv
// Two-master round-robin arbiter for the shared OPB register bus: one RE/WE strobe per transaction, fixed read latency, one-cycle ACK.
// Optional grant locking for atomic read-modify-write is enabled by defining OPB_ARB_LOCK_EN.
module opb_master_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 2,
  parameter int LOCK_TMO = 16
) (
  input  logic              OPB_CLK,
  input  logic              OPB_RST_N,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic              M0_LOCK,
  output logic              M0_ACK,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic              M1_LOCK,
  output logic              M1_ACK,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [ADDR_W-1:0] OPB_ADDR,
  output logic [DATA_W-1:0] OPB_DO,
  output logic              OPB_RE,
  output logic              OPB_WE,
  input  logic [DATA_W-1:0] OPB_DI,
  output logic [1:0]        GNT,
  output logic              BUSY
);

  typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_WAIT, ST_ACK} state_t;

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  state_t            state_reg;
  logic              owner_reg;
  logic              last_reg;
  logic              we_reg;
  logic [3:0]        cnt_reg;
  logic              pick_valid;
  logic              pick_m1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef OPB_ARB_LOCK_EN
  localparam int LW = $clog2(LOCK_TMO + 1);
  localparam logic [LW-1:0] TMO_LAST = LW'(LOCK_TMO - 1);

  logic          lock_reg;
  logic [LW-1:0] idle_cnt_reg;
  logic          owner_req;

  assign owner_req = owner_reg ? M1_REQ : M0_REQ;

  // The lock is re-armed or released at every owner ACK and times out after LOCK_TMO quiet IDLE cycles.
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      lock_reg     <= 1'b0;
      idle_cnt_reg <= '0;
    end else if (state_reg == ST_ACK) begin
      lock_reg     <= owner_reg ? M1_LOCK : M0_LOCK;
      idle_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE && lock_reg) begin
      if (owner_req) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg == TMO_LAST) begin
        lock_reg     <= 1'b0;
        idle_cnt_reg <= '0;
      end else begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end
`else
  logic lock_unused;
  assign lock_unused = M0_LOCK ^ M1_LOCK;
`endif

  // Both requesting: the master that did not win last time goes next.
  always_comb begin
    pick_valid = M0_REQ | M1_REQ;
    pick_m1    = M1_REQ & (~M0_REQ | ~last_reg);
`ifdef OPB_ARB_LOCK_EN
    if (lock_reg) begin
      pick_m1    = owner_reg;
      pick_valid = owner_req;
    end
`endif
    sel_we    = pick_m1 ? M1_WE    : M0_WE;
    sel_addr  = pick_m1 ? M1_ADDR  : M0_ADDR;
    sel_wdata = pick_m1 ? M1_WDATA : M0_WDATA;
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_reg <= ST_IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      OPB_ADDR  <= '0;
      OPB_DO    <= '0;
      OPB_RE    <= 1'b0;
      OPB_WE    <= 1'b0;
      GNT       <= 2'b00;
      BUSY      <= 1'b0;
      M0_ACK    <= 1'b0;
      M1_ACK    <= 1'b0;
      M0_RDATA  <= '0;
      M1_RDATA  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            owner_reg <= pick_m1;
            last_reg  <= pick_m1;
            we_reg    <= sel_we;
            OPB_ADDR  <= sel_addr;
            OPB_DO    <= sel_wdata;
            OPB_WE    <= sel_we;
            OPB_RE    <= ~sel_we;
            GNT       <= pick_m1 ? 2'b10 : 2'b01;
            BUSY      <= 1'b1;
            state_reg <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          OPB_RE <= 1'b0;
          OPB_WE <= 1'b0;
          if (we_reg) begin
            M0_ACK    <= ~owner_reg;
            M1_ACK    <= owner_reg;
            state_reg <= ST_ACK;
          end else if (RD_LAT_C == 4'd0) begin
            if (owner_reg) M1_RDATA <= OPB_DI;
            else           M0_RDATA <= OPB_DI;
            M0_ACK    <= ~owner_reg;
            M1_ACK    <= owner_reg;
            state_reg <= ST_ACK;
          end else begin
            cnt_reg   <= 4'd1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // cnt_reg holds the offset of the current cycle from the strobe cycle.
          if (cnt_reg == RD_LAT_C) begin
            if (owner_reg) M1_RDATA <= OPB_DI;
            else           M0_RDATA <= OPB_DI;
            M0_ACK    <= ~owner_reg;
            M1_ACK    <= owner_reg;
            state_reg <= ST_ACK;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ST_ACK: begin
          M0_ACK    <= 1'b0;
          M1_ACK    <= 1'b0;
          GNT       <= 2'b00;
          BUSY      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
